// File: rtl/pattern_detector_mealy.sv
// Serial Mealy detector for the bit pattern 1-1-0-1-0 (first bit first).
// Overlapping detection: no proper suffix of 11010 is also a prefix of it,
// so matching restarts from S_IDLE after each hit.
module pattern_detector_mealy (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  input  logic valid_i,
  output logic pattern
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_1101 = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Mealy output; invalid cycles hold the partial match.
  always_comb begin
    state_next = state;
    pattern    = rst & valid_i & (state == S_1101) & ~d_i;
    if (valid_i) begin
      case (state)
        S_IDLE:  state_next = d_i ? S_1    : S_IDLE;
        S_1:     state_next = d_i ? S_11   : S_IDLE;
        S_11:    state_next = d_i ? S_11   : S_110;
        S_110:   state_next = d_i ? S_1101 : S_IDLE;
        S_1101:  state_next = d_i ? S_11   : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_detector_mealy.sv
// Self-checking bench: a sliding-window reference model pushes the expected
// pattern value for each driven cycle into a queue; it is popped and compared
// against the DUT output before the next rising edge.
module tb_pattern_detector_mealy;

  logic clk;
  logic rst;
  logic d_i;
  logic valid_i;
  logic pattern;

  int unsigned checks;
  int unsigned errors;

  logic exp_q[$];

  // Reference model: last four valid bits since reset.
  logic [3:0]  hist;
  int unsigned nvalid;

  // Rising-edge bookkeeping.
  logic        prev_dut;
  logic        prev_exp;
  int unsigned dut_edges;
  int unsigned exp_edges;

  int unsigned lfsr;

  pattern_detector_mealy dut (
    .clk     (clk),
    .rst     (rst),
    .d_i     (d_i),
    .valid_i (valid_i),
    .pattern (pattern)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, score it, then advance the model.
  task automatic step(input string tag, input logic r, input logic v, input logic d);
    logic e;
    logic got;
    @(negedge clk);
    rst     = r;
    valid_i = v;
    d_i     = d;
    e = r && v && (nvalid >= 4) && ({hist, d} == 5'b11010);
    exp_q.push_back(e);
    #1;
    got = pattern;
    check(tag, {31'd0, got}, {31'd0, exp_q.pop_front()});
    if (got === 1'b1 && prev_dut !== 1'b1) dut_edges++;
    if (e && !prev_exp) exp_edges++;
    prev_dut = got;
    prev_exp = e;
    if (!r) begin
      hist   = '0;
      nvalid = 0;
    end else if (v) begin
      hist   = {hist[2:0], d};
      nvalid = nvalid + 1;
    end
  endtask

  // Send n valid bits, MSB of the used field first.
  task automatic send(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, 1'b1, bits[i]);
  endtask

  task automatic do_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int unsigned e0;
    int unsigned d0;
    checks = 0; errors = 0;
    hist = '0; nvalid = 0;
    prev_dut = 1'b0; prev_exp = 1'b0;
    dut_edges = 0; exp_edges = 0;
    rst = 1'b0; valid_i = 1'b0; d_i = 1'b0;

    do_reset("reset", 2);
    send("basic", 16'b11010, 5);

    do_reset("rst2", 1);
    d0 = dut_edges; e0 = exp_edges;
    send("b2b", 16'b1101011010, 10);
    check("b2b_pulses", dut_edges - d0, 2);

    send("selfloop", 16'b111010, 6);

    send("gap_pre", 16'b110, 3);
    step("gap", 1'b1, 1'b0, 1'b1);
    step("gap", 1'b1, 1'b0, 1'b0);
    step("gap", 1'b1, 1'b0, 1'b1);
    send("gap_post", 16'b10, 2);

    send("near1", 16'b11011010, 8);
    d0 = dut_edges;
    send("near2", 16'b101010, 6);
    check("near2_pulses", dut_edges - d0, 0);

    send("midrst", 16'b1101, 4);
    step("midrst_rst", 1'b0, 1'b1, 1'b0);
    step("midrst_after", 1'b1, 1'b1, 1'b0);

    // Random soak from a fixed seed.
    lfsr = 32'h1ACE_5EED;
    d0 = dut_edges; e0 = exp_edges;
    for (int i = 0; i < 600; i++) begin
      lfsr = lfsr ^ (lfsr << 13);
      lfsr = lfsr ^ (lfsr >> 17);
      lfsr = lfsr ^ (lfsr << 5);
      step("soak", 1'b1, 1'b1, lfsr[7]);
    end
    check("soak_edges", dut_edges - d0, exp_edges - e0);
    for (int i = 0; i < 4; i++) step("idle", 1'b1, 1'b0, i[0]);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_detector_mealy.md
Name: pattern_detector_mealy

Overview:
- Serial Mealy-FSM detector for the fixed 5-bit pattern 1-1-0-1-0 (first bit received first), with overlapping detection.
- Consumes one bit per clock when valid_i is high.
- Raises pattern combinationally in the same cycle the final matching bit is presented.
- Sits on a serial bit stream; the downstream logic counts rising edges of pattern.

Parameters:
- None. The pattern 11010 and its length (5) are fixed in the RTL.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- d_i  input  1  serial data bit
- valid_i  input  1  qualifies d_i; a bit is consumed only when valid_i=1
- pattern  output  1  detection flag, Mealy (combinational from state, d_i, valid_i, rst)

Behaviour:
- Reset:
  - On a rising clk with rst=0, the state goes to S_IDLE regardless of valid_i and d_i.
  - While rst=0, pattern is forced to 0.
  - The first bit is consumed on the first rising clk with rst=1 and valid_i=1.
- States (3-bit encoding, one-hot optional): S_IDLE (no prefix matched), S_1 ("1"), S_11 ("11"), S_110 ("110"), S_1101 ("1101").
- Transitions on rising clk, applied only when rst=1 and valid_i=1:
  - S_IDLE: d=1 -> S_1; d=0 -> S_IDLE
  - S_1: d=1 -> S_11; d=0 -> S_IDLE
  - S_11: d=1 -> S_11; d=0 -> S_110
  - S_110: d=1 -> S_1101; d=0 -> S_IDLE
  - S_1101: d=1 -> S_11 (suffix "11" kept); d=0 -> S_IDLE, this is the detection.
- valid_i=0: the state holds and the bit is ignored. Invalid cycles do not break a partial match; matching resumes on the next valid bit.
- Output equation: pattern = rst & valid_i & (state==S_1101) & ~d_i.
  - Purely combinational; zero-cycle latency relative to the final bit.
  - High for exactly one cycle per detection when inputs are stable across the clock.
- Overlap:
  - No proper suffix of 11010 is a prefix of it, so after a detection matching restarts from S_IDLE.
  - Minimum spacing between detections is 5 valid bits.
  - Two detections can never occur in consecutive cycles, so every detection produces a distinct rising edge on pattern.
- Reset mid-operation: any partial match is discarded; a sequence straddling the reset is not detected.
- Unknown inputs: the state register must never hold X after the first reset cycle. Any unused encodings recover to S_IDLE on the next valid bit (default branch).
- Implementation: one state register plus next-state and output logic. No other storage.

Test Plan:
- Reset: rst=0 for 2 cycles with valid_i=1, d_i=1 -> pattern=0 throughout; after release, stream 1,1,0,1,0 -> pattern=1 only during the 5th bit's cycle.
- Overlap/back-to-back: valid stream 1,1,0,1,0,1,1,0,1,0 -> exactly 2 pulses, on bits 5 and 10; stream 1,1,1,0,1,0 -> 1 pulse on bit 6 (S_11 self-loop).
- Valid gaps: bits 1,1,0 then valid_i=0 for 3 cycles with d_i toggling, then 1,0 -> 1 pulse on the final valid bit; pattern=0 during the gap cycles.
- Near-misses: 1,1,0,1,1,0,1,0 -> 1 pulse on bit 8 (S_1101 + 1 -> S_11); 1,0,1,0,1,0 -> 0 pulses.
- Mid-sequence reset: 1,1,0,1, then rst=0 for one cycle, then rst=1 with 0 -> pattern stays 0.
- Random soak: 600 valid random bits from a fixed seed, then valid_i=0 -> count of pattern rising edges equals the reference-model count of overlapping 11010 occurrences; pattern=0 once valid_i drops.
